// File: rtl/phase_pkg.sv
// phase_pkg: shared phase constants, FSM states and word layout for phase_sequencer.
package phase_pkg;
  localparam int DATA_W = 289;
  typedef logic [0:3] phase_t;
  localparam phase_t PKT_FIRST_WORD  = 4'd1;
  localparam phase_t PKT_SECOND_WORD = 4'd2;
  localparam phase_t PKT_INNER_WORD  = 4'd4;
  typedef enum logic [1:0] {IDLE, SECOND, INNER, DROP} seq_state_e;
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } word_t;
endpackage

// File: rtl/phase_skid_fifo.sv
// phase_skid_fifo: 2-entry order-preserving FIFO with a registered ready (ready = count < 2).
module phase_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_pop,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         r_ready;
  logic         w_push;
  logic [1:0]   w_cnt_nxt;

  assign w_push    = i_valid && r_ready;
  assign o_pop     = i_pop && (r_cnt != 2'd0);
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(o_pop);
  assign o_ready   = r_ready;
  assign o_data    = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_cnt   <= 2'd0;
      r_ready <= 1'b1;
    end else begin
      r_rd    <= r_rd ^ o_pop;
      r_wr    <= r_wr ^ w_push;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_cnt_nxt != 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: buffers a framed word stream and tags each popped word with its packet phase.
// Optional PHASE_SEQ_STATS_EN adds packet/word/error statistics counters.
module phase_sequencer #(
  parameter int DATA_W    = phase_pkg::DATA_W,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = $clog2(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sop,
  input  logic              s_eop,
  input  logic [DATA_W-1:0] s_data,
  input  logic              i_stall,
  output logic              o_ready,
  output logic [0:3]        o_state,
  output logic [DATA_W-1:0] o_text,
  output logic              o_last,
  output logic              o_err_orphan,
  output logic              o_err_sop,
  output logic              o_err_len
`ifdef PHASE_SEQ_STATS_EN
  ,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_word_cnt,
  output logic [15:0]       o_err_cnt
`endif
);
  import phase_pkg::*;

  logic [DATA_W+1:0] w_word;
  logic              w_pop;
  logic              w_sop;
  logic              w_eop;
  logic [DATA_W-1:0] w_data;
  seq_state_e        r_st;
  seq_state_e        w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_emit;
  logic              w_at_max;
  logic              w_last;
  logic              w_e_orph;
  logic              w_e_sop;
  logic              w_e_len;
  logic              w_open;
  phase_t            w_ph;
  logic              r_ready;
  phase_t            r_state;
  logic [DATA_W-1:0] r_text;
  logic              r_last;
  logic              r_e_orph;
  logic              r_e_sop;
  logic              r_e_len;

  phase_skid_fifo #(.W(DATA_W + 2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (s_valid),
    .o_ready (s_ready),
    .i_data  ({s_sop, s_eop, s_data}),
    .i_pop   (!i_stall),
    .o_pop   (w_pop),
    .o_data  (w_word)
  );

  assign w_sop  = w_word[DATA_W+1];
  assign w_eop  = w_word[DATA_W];
  assign w_data = w_word[DATA_W-1:0];
  assign w_open = (r_st == SECOND) || (r_st == INNER);

  // A sop word always opens a fresh packet, whatever state it lands in.
  always_comb begin
    w_nxt     = r_st;
    w_cnt_nxt = r_cnt;
    w_emit    = 1'b0;
    w_ph      = '0;
    w_at_max  = 1'b0;
    w_e_orph  = 1'b0;
    w_e_sop   = 1'b0;
    if (w_pop) begin
      if (w_sop) begin
        w_emit    = 1'b1;
        w_ph      = PKT_FIRST_WORD;
        w_cnt_nxt = CNT_W'(1);
        w_at_max  = MAX_WORDS == 1;
        w_e_sop   = w_open;
      end else if (w_open) begin
        w_emit    = 1'b1;
        w_ph      = (r_st == SECOND) ? PKT_SECOND_WORD : PKT_INNER_WORD;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_at_max  = r_cnt == CNT_W'(MAX_WORDS - 1);
      end else begin
        w_e_orph = r_st == IDLE;
        w_nxt    = w_eop ? IDLE : r_st;
      end
      if (w_emit) w_nxt = w_eop ? IDLE : w_at_max ? DROP : w_sop ? SECOND : INNER;
    end
  end

  assign w_last  = w_eop || w_at_max;
  assign w_e_len = w_emit && w_at_max && !w_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_state  <= '0;
      r_text   <= '0;
      r_last   <= 1'b0;
      r_e_orph <= 1'b0;
      r_e_sop  <= 1'b0;
      r_e_len  <= 1'b0;
    end else begin
      r_st     <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_emit;
      r_state  <= w_ph;
      r_last   <= w_emit && w_last;
      r_e_orph <= w_e_orph;
      r_e_sop  <= w_e_sop;
      r_e_len  <= w_e_len;
      if (w_emit) r_text <= w_data;
    end
  end

  assign o_ready      = r_ready;
  assign o_state      = r_state;
  assign o_text       = r_text;
  assign o_last       = r_last;
  assign o_err_orphan = r_e_orph;
  assign o_err_sop    = r_e_sop;
  assign o_err_len    = r_e_len;

`ifdef PHASE_SEQ_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_word_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_pkt_cnt  <= r_pkt_cnt + 32'(w_emit && w_last);
      r_word_cnt <= r_word_cnt + 32'(w_emit);
      if ((w_e_orph || w_e_sop || w_e_len) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_word_cnt = r_word_cnt;
  assign o_err_cnt  = r_err_cnt;
`endif
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench; a packet-level model predicts emitted words and error pulses.
module tb_phase_sequencer;
  import phase_pkg::*;
  localparam int DW = DATA_W;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sop = 1'b0;
  logic          s_eop = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          i_stall = 1'b0;
  logic          o_ready;
  logic [0:3]    o_state;
  logic [DW-1:0] o_text;
  logic          o_last;
  logic          o_err_orphan;
  logic          o_err_sop;
  logic          o_err_len;
`ifdef PHASE_SEQ_STATS_EN
  logic [31:0]   o_pkt_cnt;
  logic [31:0]   o_word_cnt;
  logic [15:0]   o_err_cnt;
`endif

  phase_sequencer #(.MAX_WORDS(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_sop        (s_sop),
    .s_eop        (s_eop),
    .s_data       (s_data),
    .i_stall      (i_stall),
    .o_ready      (o_ready),
    .o_state      (o_state),
    .o_text       (o_text),
    .o_last       (o_last),
    .o_err_orphan (o_err_orphan),
    .o_err_sop    (o_err_sop),
    .o_err_len    (o_err_len)
`ifdef PHASE_SEQ_STATS_EN
    ,
    .o_pkt_cnt    (o_pkt_cnt),
    .o_word_cnt   (o_word_cnt),
    .o_err_cnt    (o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    st;
    logic [DW-1:0] txt;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            err_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            stall_left = 0;
  bit            rnd_stall = 0;
  bit            saw_busy = 0;
  bit            prev_stall = 0;
  bit            have_txt = 0;
  bit            m_in = 0;
  bit            m_drop = 0;
  int            m_n = 0;
  logic [DW-1:0] last_txt = '0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_stall <= i_stall;
  end

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] w);
    checks++;
    if (a !== w) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, w);
    end
  endtask

  task automatic chk_err(input string n, input logic p, input int code);
    if (p) begin
      checks++;
      if (err_q.size() == 0 || err_q[0] != code) begin
        errors++;
        $display("FAIL %s got pulse want code %0d", n, (err_q.size() == 0) ? 0 : err_q[0]);
      end else void'(err_q.pop_front());
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [319:0] t;
    for (int k = 0; k < 10; k++) t[k*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  // Packet-level view: which word of the packet this is, and whether we are inside/dropping one.
  task automatic model(input logic sop, input logic eop, input logic [DW-1:0] d, input int c);
    exp_t e;
    if (sop) begin
      if (m_in) err_q.push_back(2);
      m_in   = 1;
      m_drop = 0;
      m_n    = 0;
    end else if (!m_in) begin
      if (!m_drop) err_q.push_back(1);
      else if (eop) m_drop = 0;
      return;
    end
    m_n++;
    e.st   = (m_n == 1) ? 4'd1 : (m_n == 2) ? 4'd2 : 4'd4;
    e.txt  = d;
    e.last = eop || (m_n == MW);
    e.cyc  = c;
    exp_q.push_back(e);
    if (m_n == MW && !eop) begin
      err_q.push_back(3);
      m_drop = 1;
    end
    if (e.last) m_in = 0;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d, input bit timed);
    int t = 0;
    bit rdy = 0;
    int c = 0;
    s_valid = 1'b1;
    s_sop   = sop;
    s_eop   = eop;
    s_data  = d;
    forever begin
      if (stall_left > 0) begin
        i_stall = 1'b1;
        stall_left--;
      end else i_stall = rnd_stall && ($urandom_range(0, 3) == 0);
      rdy = s_ready;
      c   = cyc;
      if (!rdy) saw_busy = 1;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      if (++t > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got s_ready 0 want 1");
        break;
      end
    end
    if (rdy) model(sop, eop, d, timed ? c + 2 : -1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      i_stall = rnd_stall && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    i_stall = 1'b0;
  endtask

  task automatic chk_rst();
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    chk("rst_o_ready", DW'(o_ready), '0);
    chk("rst_o_state", DW'(o_state), '0);
    chk("rst_o_text", o_text, '0);
    chk("rst_o_last", DW'(o_last), '0);
    chk("rst_errs", DW'({o_err_orphan, o_err_sop, o_err_len}), '0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall_gap", DW'(o_ready && prev_stall), '0);
      if (o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got state %0d want none", o_state);
        end else begin
          mon_e = exp_q.pop_front();
          chk("state", DW'(o_state), DW'(mon_e.st));
          chk("text", o_text, mon_e.txt);
          chk("last", DW'(o_last), DW'(mon_e.last));
          if (mon_e.cyc >= 0) chk("latency", DW'(cyc), DW'(mon_e.cyc));
          last_txt = mon_e.txt;
          have_txt = 1;
        end
      end else begin
        chk("idle_state", DW'(o_state), '0);
        chk("idle_last", DW'(o_last), '0);
        if (have_txt) chk("text_hold", o_text, last_txt);
      end
      chk_err("err_orphan", o_err_orphan, 1);
      chk_err("err_sop", o_err_sop, 2);
      chk_err("err_len", o_err_len, 3);
    end
  end

  initial begin
    int t;
    int len;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_rst();
    send(1, 1, DW'(1), 1);
    idle(4);
    for (int i = 0; i < 5; i++) send(i == 0, i == 4, rnd(), 0);
    idle(4);
    saw_busy = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) stall_left = 3;
      send(i == 0, i == 4, rnd(), 0);
    end
    chk("stall_backpressure", DW'(saw_busy), DW'(1));
    idle(6);
    send(0, 0, rnd(), 0);
    send(1, 0, rnd(), 0);
    send(0, 1, rnd(), 0);
    idle(4);
    send(1, 0, rnd(), 0);
    send(0, 0, rnd(), 0);
    send(1, 0, rnd(), 0);
    send(0, 1, rnd(), 0);
    idle(4);
    for (int i = 0; i < MW + 2; i++) send(i == 0, i == MW + 1, rnd(), 0);
    send(1, 1, rnd(), 0);
    idle(4);
    stall_left = 1000;
    send(1, 0, rnd(), 0);
    send(0, 0, rnd(), 0);
    chk("buffered_before_reset", DW'(exp_q.size()), DW'(2));
    #2 rst_n = 1'b0;
    exp_q.delete();
    err_q.delete();
    m_in       = 0;
    m_drop     = 0;
    m_n        = 0;
    last_txt   = '0;
    stall_left = 0;
    i_stall    = 1'b0;
    s_valid    = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_rst();
    send(1, 1, rnd(), 0);
    idle(4);
    rnd_stall = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        send((i == 0) ^ ($urandom_range(0, 19) == 0), (i == len - 1) ^ ($urandom_range(0, 19) == 0), rnd(), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_stall = 0;
    idle(2);
    t = 0;
    while ((exp_q.size() > 0 || err_q.size() > 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_words", DW'(exp_q.size()), '0);
    chk("drain_errs", DW'(err_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
